arbiter_weighted: RTL and testbench

Parametrised weighted round-robin arbiter with quantum counting, bus lock and encoded grant output. Each port may hold the shared resource for up to a per-port number of cycles ("weight"). Ownership passes back-to-back with no idle cycle. It is the next-generation drop-in for masters sharing one bus or memory port.

---
 rtl/arbiter_weighted.sv | 192 +++++++++++++++++++
 tb/tb_arbiter_weighted.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_weighted.sv
// ---------------------------------------------------------------------------
// arbiter_weighted
//
// Weighted round-robin arbiter with quantum counting, bus lock and an
// encoded grant. The owning port may keep the shared resource for up to its
// per-port weight in cycles (a weight of 0 counts as 1). Ownership passes
// back-to-back with no idle cycle between owners.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous, active-high reset
//   request   bit i high = port i requests the resource
//   weight    port i quantum in weight[i*WEIGHT_W +: WEIGHT_W]
//   lock      owner keeps the grant beyond its quantum while high
//   grant     registered one-hot grant, all zero when idle
//   grant_id  binary index of the granted port, 0 when idle
//   active    registered, high whenever grant is non-zero
//   last      high in the owner's final quantum cycle (active, cnt==1, ~lock)
//   fsm_state debug view of the FSM: 0 = IDLE, 1 = OWNED
//
// Handshake: a port raises request and keeps it high for as long as it wants
// the resource; it owns the resource in every cycle its grant bit is high.
// The arbiter samples request at each rising edge, so an owner that drops
// request keeps its grant for that one cycle and loses it at the next edge.
// ---------------------------------------------------------------------------
module arbiter_weighted #(
    parameter int NUM_PORTS = 6,
    parameter int WEIGHT_W  = 4,
    parameter int ID_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:NUM_PORTS-1]          request,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
    input  logic                          lock,
    output logic [0:NUM_PORTS-1]          grant,
    output logic [ID_W-1:0]               grant_id,
    output logic                          active,
    output logic                          last,
    output logic                          fsm_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]        id_d;
    logic                   active_d;
    logic [0:NUM_PORTS-1]   grant_d;

    // Request and weight padded to the full grant_id range so that they can
    // be indexed directly by an ID_W-bit port number.
    logic [(2**ID_W)-1:0]   req_pad;
    logic [WEIGHT_W-1:0]    w_pad [0:(2**ID_W)-1];

    logic [ID_W-1:0]        release_ptr;
    logic [ID_W-1:0]        search_from;
    logic [ID_W:0]          sum_w;
    logic [ID_W-1:0]        cand;
    logic                   win_found;
    logic [ID_W-1:0]        win_id;
    logic [WEIGHT_W-1:0]    eff_w;
    logic                   owner_release;
    logic                   do_load;

    always_comb begin
        req_pad = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_pad[i] = request[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2**ID_W; i++) begin
            w_pad[i] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_pad[i] = weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    // Port after the current owner, wrapping at NUM_PORTS (not at 2**ID_W).
    assign release_ptr = (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;

    // When owned, the only search that matters is the one on release, which
    // starts just past the owner; when idle it starts at the saved pointer.
    assign search_from = (state_q == OWNED) ? release_ptr : ptr_q;

    // Rotating priority search: first requester at search_from, +1, ... mod N.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum_w     = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum_w = {1'b0, search_from} + (ID_W+1)'(k);
            if (sum_w >= (ID_W+1)'(NUM_PORTS)) begin
                sum_w = sum_w - (ID_W+1)'(NUM_PORTS);
            end
            cand = sum_w[ID_W-1:0];
            if (!win_found && req_pad[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // A zero weight still buys one cycle of ownership.
    assign eff_w = (w_pad[win_id] == '0) ? WEIGHT_W'(1) : w_pad[win_id];

    // Owner gives up the resource when it stops requesting, or when its
    // quantum is spent and lock is not holding it.
    assign owner_release = !req_pad[grant_id] || ((cnt_q == WEIGHT_W'(1)) && !lock);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        id_d     = grant_id;
        active_d = active;
        do_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    do_load = 1'b1;
                end
            end
            OWNED: begin
                if (owner_release) begin
                    ptr_d = release_ptr;
                    if (win_found) begin
                        do_load = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        id_d     = '0;
                        active_d = 1'b0;
                        cnt_d    = '0;
                    end
                end else if (cnt_q > WEIGHT_W'(1)) begin
                    cnt_d = cnt_q - WEIGHT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                id_d     = '0;
                active_d = 1'b0;
                cnt_d    = '0;
            end
        endcase

        if (do_load) begin
            state_d  = OWNED;
            id_d     = win_id;
            active_d = 1'b1;
            cnt_d    = eff_w;
        end
    end

    always_comb begin
        grant_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_d[i] = active_d && (id_d == ID_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant    <= '0;
            grant_id <= '0;
            active   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant    <= grant_d;
            grant_id <= id_d;
            active   <= active_d;
        end
    end

    assign last      = active && (cnt_q == WEIGHT_W'(1)) && !lock;
    assign fsm_state = (state_q == OWNED);

endmodule

// File: tb/tb_arbiter_weighted.sv
module tb_arbiter_weighted;

  localparam int NP = 4;
  localparam int WW = 4;
  localparam int IW = 3;

  logic              clk;
  logic              rst;
  logic [0:NP-1]     request;
  logic [NP*WW-1:0]  weight;
  logic              lock;
  logic [0:NP-1]     grant;
  logic [IW-1:0]     grant_id;
  logic              active;
  logic              last;
  logic              fsm_state;

  int vectors = 0;
  int miscompares = 0;

  arbiter_weighted #(.NUM_PORTS(NP), .WEIGHT_W(WW), .ID_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .request(request),
    .weight(weight),
    .lock(lock),
    .grant(grant),
    .grant_id(grant_id),
    .active(active),
    .last(last),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural reference: who owns, how many beats remain, where the
  // rotating priority starts
  typedef struct {
    int active;
    int owner;
    int rem;
    int ptr;
  } mstate_t;

  mstate_t m = '{0, 0, 0, 0};

  function automatic int search(int from);
    for (int k = 0; k < NP; k++) begin
      int idx = (from + k) % NP;
      if (request[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int eff(int p);
    int w = int'(weight[p*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic mstate_t step(mstate_t s);
    mstate_t n = s;
    int win;
    if (s.active == 0) begin
      win = search(s.ptr);
      if (win >= 0) begin
        n.active = 1; n.owner = win; n.rem = eff(win);
      end
    end else if (!request[s.owner] || (s.rem == 1 && !lock)) begin
      n.ptr = (s.owner + 1) % NP;
      win = search(n.ptr);
      if (win >= 0) begin
        n.active = 1; n.owner = win; n.rem = eff(win);
      end else begin
        n.active = 0; n.owner = 0; n.rem = 0;
      end
    end else if (s.rem > 1) begin
      n.rem = s.rem - 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{0, 0, 0, 0};
    else     m <= step(m);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    logic [0:NP-1] exp_g;
    exp_g = '0;
    for (int i = 0; i < NP; i++) exp_g[i] = (m.active != 0) && (m.owner == i);
    chk("grant", int'(grant), int'(exp_g));
    chk("grant_id", int'(grant_id), (m.active != 0) ? m.owner : 0);
    chk("active", int'(active), m.active);
    chk("last", int'(last), ((m.active != 0) && m.rem == 1 && !lock) ? 1 : 0);
    chk("fsm_state", int'(fsm_state), m.active);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int p, input int v);
    weight[p*WW +: WW] = WW'(v);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_id"}, int'(grant_id), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_last"}, int'(last), 0);
  endtask

  // called 1 time unit after a rising edge; reset is pulsed between edges
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_zero(tag);
    #2;
    rst = 1'b0;
  endtask

  int exp_id[7]   = '{0, 0, 1, 2, 2, 2, 3};
  int exp_last[7] = '{0, 1, 1, 0, 0, 1, 1};

  initial begin
    rst = 1'b1;
    request = '1;
    weight = '0;
    lock = 1'b0;
    set_w(0, 2); set_w(1, 1); set_w(2, 3); set_w(3, 1);
    repeat (2) tick();

    // reset held with all requests high, then fairness sequence
    check_zero("rst_hold");
    rst = 1'b0;
    for (int j = 0; j < 14; j++) begin
      tick();
      chk("wrr_id", int'(grant_id), exp_id[j % 7]);
      chk("wrr_last", int'(last), exp_last[j % 7]);
      chk("wrr_active", int'(active), 1);
    end

    // early release by the owner
    request = '0;
    do_reset("t3_rst");
    set_w(0, 2); set_w(2, 5);
    request[2] = 1'b1;
    tick(); chk("t3_g2_a", int'(grant[2]), 1);
    request[0] = 1'b1;
    tick(); chk("t3_g2_b", int'(grant[2]), 1);
    tick(); chk("t3_g2_c", int'(grant[2]), 1);
    request[2] = 1'b0;
    tick();
    chk("t3_next_id", int'(grant_id), 0);
    chk("t3_next_active", int'(active), 1);

    // lock holds a weight-1 owner
    request = '0;
    do_reset("t4_rst");
    set_w(1, 1);
    request[1] = 1'b1;
    tick(); chk("t4_own", int'(grant_id), 1);
    lock = 1'b1;
    request[3] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t4_hold_id", int'(grant_id), 1);
      chk("t4_hold_last", int'(last), 0);
    end
    lock = 1'b0;
    tick(); chk("t4_after_lock", int'(grant_id), 3);

    // zero weight, sole requester
    request = '0;
    do_reset("t5_rst");
    set_w(3, 0);
    request[3] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t5_id", int'(grant_id), 3);
      chk("t5_active", int'(active), 1);
      chk("t5_last", int'(last), 1);
    end
    request[3] = 1'b0;
    tick(); chk("t5_drop", int'(active), 0);

    // async reset mid-ownership clears the pointer
    request = '0;
    do_reset("t6_rst0");
    set_w(2, 3);
    request[2] = 1'b1;
    tick();
    tick(); chk("t6_own", int'(grant_id), 2);
    do_reset("t6_rst");
    request = '0;
    request[1] = 1'b1;
    request[2] = 1'b1;
    tick(); chk("t6_first", int'(grant_id), 1);

    // randomized traffic against the model
    for (int j = 0; j < 3000; j++) begin
      tick();
      if ($urandom_range(0, 9) < 3) request = NP'($urandom_range(0, (1 << NP) - 1));
      if ($urandom_range(0, 19) == 0) set_w($urandom_range(0, NP - 1), $urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) lock = ~lock;
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
